// File: rtl/rvv_alu_sequencer_if.sv
// Bundle of the command, ALU and write-back signals around the sequencer.
// All three channels use valid/ready semantics: a transfer happens in the
// cycle where valid and ready are both high on a rising clk edge; once valid
// is raised, the payload stays stable until that transfer takes place.
interface rvv_alu_sequencer_if #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
);
  // Command channel from vector decode
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [5:0]                 cmd_opcode;
  logic [2:0]                 cmd_op_type;
  logic [2:0]                 cmd_vsew;
  logic [10:0]                cmd_vl;
  logic                       cmd_mask;
  logic [VLEN-1:0]            cmd_vs1;
  logic [VLEN-1:0]            cmd_vs2;

  // ALU wrapper side
  logic                       alu_run;
  logic [5:0]                 alu_opcode;
  logic [2:0]                 alu_op_type;
  logic [2:0]                 alu_vsew;
  logic [10:0]                alu_vl;
  logic                       alu_mask;
  logic [VLEN-1:0]            alu_vs1;
  logic [VLEN-1:0]            alu_vs2;
  logic [(64<<NB_LANES)-1:0]  alu_vd;
  logic [(10<<NB_LANES)-1:0]  alu_regi;
  logic [(1<<NB_LANES)-1:0]   alu_res;
  logic                       alu_done;

  // Register-file write-back channel
  logic                       wb_valid;
  logic                       wb_ready;
  logic [VLEN-1:0]            wb_data;
  logic [VLEN/8-1:0]          wb_be;
  logic                       wb_err;

  // Sequencer view
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op_type, cmd_vsew, cmd_vl, cmd_mask,
           cmd_vs1, cmd_vs2,
    output cmd_ready,
    output alu_run, alu_opcode, alu_op_type, alu_vsew, alu_vl, alu_mask,
           alu_vs1, alu_vs2,
    input  alu_vd, alu_regi, alu_res, alu_done,
    output wb_valid, wb_data, wb_be, wb_err,
    input  wb_ready
  );

  // Environment view (decode stage, ALU wrapper, register file)
  modport master (
    output cmd_valid, cmd_opcode, cmd_op_type, cmd_vsew, cmd_vl, cmd_mask,
           cmd_vs1, cmd_vs2,
    input  cmd_ready,
    input  alu_run, alu_opcode, alu_op_type, alu_vsew, alu_vl, alu_mask,
           alu_vs1, alu_vs2,
    output alu_vd, alu_regi, alu_res, alu_done,
    input  wb_valid, wb_data, wb_be, wb_err,
    output wb_ready
  );
endinterface

// File: rtl/rvv_alu_sequencer.sv
// Issue-and-collect controller for the multi-lane vector ALU wrapper.
// Accepts one command, keeps alu_run and operands stable while the ALU works,
// merges per-lane element results into a VLEN-wide image with byte enables,
// then offers the image to the register file.
module rvv_alu_sequencer #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  rvv_alu_sequencer_if.slave     bus,
  output logic [1:0]             dbg_state
);

  localparam int LANES  = 1 << NB_LANES;
  localparam int NBYTES = VLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [5:0]        opcode_q;
  logic [2:0]        op_type_q;
  logic [2:0]        vsew_q;
  logic [10:0]       vl_q;
  logic              mask_q;
  logic [VLEN-1:0]   vs1_q;
  logic [VLEN-1:0]   vs2_q;
  logic [10:0]       vl_eff_q;

  logic [VLEN-1:0]   data_q;
  logic [NBYTES-1:0] be_q;
  logic              err_q;
  logic [10:0]       cnt_q;
  logic [7:0]        tmo_q;

  logic              accept;
  logic              tmo_hit;
  logic [31:0]       max_elems;
  logic [10:0]       vl_eff_new;

  logic [VLEN-1:0]   cap_data;
  logic [NBYTES-1:0] cap_be;
  logic [10:0]       cap_cnt;
  logic [LANES-1:0]  hit;
  logic [LANES-1:0]  seen;
  logic              dup;
  logic [2:0]        sew_mask;

  assign accept  = bus.cmd_valid && (state == S_IDLE);
  assign tmo_hit = (tmo_q == 8'(TIMEOUT - 1));

  // Elements that fit in one register at the requested SEW; vl is clamped to it
  assign max_elems  = 32'(VLEN) >> ({29'd0, bus.cmd_vsew} + 32'd3);
  assign vl_eff_new = ({21'd0, bus.cmd_vl} < max_elems) ? bus.cmd_vl : max_elems[10:0];

  // Byte offset mask inside one element (SEW/8 - 1)
  assign sew_mask = {vsew_q >= 3'd3, vsew_q >= 3'd2, vsew_q >= 3'd1};

  // Merge this cycle's lane results into the image; count only first captures
  always_comb begin
    cap_data = data_q;
    cap_be   = be_q;
    cap_cnt  = cnt_q;
    hit      = '0;
    seen     = '0;
    dup      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      hit[k] = bus.alu_res[k] && ({1'b0, bus.alu_regi[10*k +: 10]} < vl_eff_q);
    end
    for (int b = 0; b < NBYTES; b++) begin
      for (int k = 0; k < LANES; k++) begin
        if (hit[k] && ((32'(b) >> vsew_q) == {22'd0, bus.alu_regi[10*k +: 10]})) begin
          if (be_q[b]) seen[k] = 1'b1;
          cap_data[8*b +: 8] = bus.alu_vd[64*k + 8*int'(3'(b) & sew_mask) +: 8];
          cap_be[b]          = 1'b1;
        end
      end
    end
    for (int k = 0; k < LANES; k++) begin
      dup = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (hit[j] && !seen[j] && (bus.alu_regi[10*j +: 10] == bus.alu_regi[10*k +: 10]))
          dup = 1'b1;
      end
      if (hit[k] && !seen[k] && !dup) cap_cnt = cap_cnt + 11'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.cmd_vsew > 3'd3)      state_n = S_WB;
          else if (vl_eff_new == 11'd0) state_n = S_WB;
          else                          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.alu_done || tmo_hit) state_n = S_WB;
      end
      S_WB: begin
        if (bus.wb_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Command latch: operands stay put from one accept to the next
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q  <= '0;
      op_type_q <= '0;
      vsew_q    <= '0;
      vl_q      <= '0;
      mask_q    <= 1'b0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vl_eff_q  <= '0;
    end else if (accept) begin
      opcode_q  <= bus.cmd_opcode;
      op_type_q <= bus.cmd_op_type;
      vsew_q    <= bus.cmd_vsew;
      vl_q      <= bus.cmd_vl;
      mask_q    <= bus.cmd_mask;
      vs1_q     <= bus.cmd_vs1;
      vs2_q     <= bus.cmd_vs2;
      vl_eff_q  <= vl_eff_new;
    end
  end

  // Result buffer, capture and timeout counters, error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      be_q   <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      tmo_q  <= '0;
    end else if (accept) begin
      data_q <= '0;
      be_q   <= '0;
      cnt_q  <= '0;
      tmo_q  <= '0;
      err_q  <= (bus.cmd_vsew > 3'd3);
    end else if (state == S_RUN) begin
      data_q <= cap_data;
      be_q   <= cap_be;
      cnt_q  <= cap_cnt;
      if (bus.alu_done)  err_q <= (cap_cnt != vl_eff_q);
      else if (tmo_hit)  err_q <= 1'b1;
      else               tmo_q <= tmo_q + 8'd1;
    end
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.alu_run     = (state == S_RUN);
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_op_type = op_type_q;
  assign bus.alu_vsew    = vsew_q;
  assign bus.alu_vl      = vl_q;
  assign bus.alu_mask    = mask_q;
  assign bus.alu_vs1     = vs1_q;
  assign bus.alu_vs2     = vs2_q;
  assign bus.wb_valid    = (state == S_WB);
  assign bus.wb_data     = data_q;
  assign bus.wb_be       = be_q;
  assign bus.wb_err      = err_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_rvv_alu_sequencer.sv
// Bench for rvv_alu_sequencer: drives commands and a behavioural two-lane ALU,
// keeps an expected image per command in a queue and checks write-backs.
module tb_rvv_alu_sequencer;

  localparam int VLEN     = 128;
  localparam int NB_LANES = 1;
  localparam int NBYTES   = VLEN / 8;
  localparam int EW       = 1 + NBYTES + VLEN;
  localparam int OPW      = 6 + 3 + 3 + 11 + 1 + 2*VLEN;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  rvv_alu_sequencer_if #(.VLEN(VLEN), .NB_LANES(NB_LANES)) bus ();

  rvv_alu_sequencer #(.VLEN(VLEN), .NB_LANES(NB_LANES), .TIMEOUT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: {err, be, data}
  logic [EW-1:0]     exp_q[$];
  logic [OPW-1:0]    exp_ops;
  int                cur_sew_bytes;
  int                cur_vl_eff;
  logic [VLEN-1:0]   m_data;
  logic [NBYTES-1:0] m_be;

  function automatic logic [OPW-1:0] dut_ops();
    return {bus.alu_opcode, bus.alu_op_type, bus.alu_vsew, bus.alu_vl, bus.alu_mask,
            bus.alu_vs1, bus.alu_vs2};
  endfunction

  // Reference capture of one element into the expected image
  function automatic void model_capture(int idx, logic [63:0] d);
    if (idx < cur_vl_eff) begin
      for (int bb = 0; bb < cur_sew_bytes; bb++) begin
        m_data[(idx*cur_sew_bytes + bb)*8 +: 8] = d[bb*8 +: 8];
        m_be[idx*cur_sew_bytes + bb] = 1'b1;
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_op_type = '0;
    bus.cmd_vsew    = '0;
    bus.cmd_vl      = '0;
    bus.cmd_mask    = 1'b0;
    bus.cmd_vs1     = '0;
    bus.cmd_vs2     = '0;
    bus.alu_vd      = '0;
    bus.alu_regi    = '0;
    bus.alu_res     = '0;
    bus.alu_done    = 1'b0;
    bus.wb_ready    = 1'b0;
  endtask

  // Offer one command and hold it for the accept cycle; returns at N+1 (+#1)
  task automatic issue(input logic [2:0] sew, input logic [10:0] vl);
    int t;
    logic [VLEN-1:0] v1, v2;
    logic [5:0] opc;
    logic [2:0] opt;
    logic msk;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL issue_ready: cmd_ready=%b required 1", bus.cmd_ready);
    else n_pass++;
    v1  = {$urandom(), $urandom(), $urandom(), $urandom()};
    v2  = {$urandom(), $urandom(), $urandom(), $urandom()};
    opc = 6'($urandom_range(0, 63));
    opt = 3'(1 << $urandom_range(0, 2));
    msk = 1'($urandom_range(0, 1));
    bus.cmd_valid = 1'b1; bus.cmd_opcode = opc; bus.cmd_op_type = opt;
    bus.cmd_vsew = sew; bus.cmd_vl = vl; bus.cmd_mask = msk;
    bus.cmd_vs1 = v1; bus.cmd_vs2 = v2;
    exp_ops = {opc, opt, sew, vl, msk, v1, v2};
    cur_sew_bytes = 1 << sew;
    if (sew > 3'd3) cur_vl_eff = 0;
    else cur_vl_eff = (int'(vl) < VLEN / (8 << sew)) ? int'(vl) : VLEN / (8 << sew);
    m_data = '0;
    m_be   = '0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = ~opc; bus.cmd_vs1 = ~v1; bus.cmd_vs2 = ~v2;
    bus.cmd_vl = ~vl; bus.cmd_vsew = ~sew;
  endtask

  // One ALU cycle; index < 0 leaves that lane idle
  task automatic beat(input int i0, input int i1, input bit done);
    logic [63:0] d0, d1;
    d0 = {$urandom(), $urandom()};
    d1 = {$urandom(), $urandom()};
    if (i1 == i0) d1 = d0;
    bus.alu_res  = {i1 >= 0, i0 >= 0};
    bus.alu_regi = {10'((i1 >= 0) ? i1 : $urandom_range(0, 15)),
                    10'((i0 >= 0) ? i0 : $urandom_range(0, 15))};
    bus.alu_vd   = {d1, d0};
    bus.alu_done = done;
    if (i0 >= 0) model_capture(i0, d0);
    if (i1 >= 0) model_capture(i1, d1);
    @(posedge clk); #1;
    bus.alu_res  = '0;
    bus.alu_done = 1'b0;
    bus.alu_vd   = '0;
  endtask

  // Wait for wb_valid, optionally stall, then handshake and score
  task automatic collect(input int stall, input string name);
    int t;
    bit stable_ok;
    logic [EW-1:0] snap, exp;
    t = 0;
    while (bus.wb_valid !== 1'b1 && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (bus.wb_valid !== 1'b1) begin
      n_checks++;
      $display("FAIL %s_wb_timeout: wb_valid=%b required 1", name, bus.wb_valid);
      void'(exp_q.pop_front());
      return;
    end
    snap = {bus.wb_err, bus.wb_be, bus.wb_data};
    if (stall > 0) begin
      stable_ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if ({bus.wb_err, bus.wb_be, bus.wb_data} !== snap || bus.cmd_ready !== 1'b0 ||
            bus.wb_valid !== 1'b1) stable_ok = 1'b0;
      end
      n_checks++;
      if (!stable_ok) $display("FAIL %s_stall_hold: outputs changed under backpressure", name);
      else n_pass++;
    end
    bus.wb_ready = 1'b1;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s_sb_empty: write-back with no expected entry", name);
    end else begin
      exp = exp_q.pop_front();
      if ({bus.wb_err, bus.wb_be, bus.wb_data} !== exp)
        $display("FAIL %s_result: err=%b be=%h data=%h required err=%b be=%h data=%h", name,
                 bus.wb_err, bus.wb_be, bus.wb_data, exp[EW-1], exp[EW-2 -: NBYTES], exp[VLEN-1:0]);
      else n_pass++;
    end
    n_checks++;
    if (dut_ops() !== exp_ops) $display("FAIL %s_operands: alu_* = %h required %h", name, dut_ops(), exp_ops);
    else n_pass++;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      $display("FAIL %s_after_hs: cmd_ready=%b wb_valid=%b required 1 0", name, bus.cmd_ready, bus.wb_valid);
    else n_pass++;
  endtask

  task automatic check_run_started(input string name);
    n_checks++;
    if (bus.alu_run !== 1'b1 || bus.cmd_ready !== 1'b0)
      $display("FAIL %s_run_start: alu_run=%b cmd_ready=%b required 1 0", name, bus.alu_run, bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic check_done_timing(input string name);
    n_checks++;
    if (bus.alu_run !== 1'b0 || bus.wb_valid !== 1'b1)
      $display("FAIL %s_done_timing: alu_run=%b wb_valid=%b required 0 1", name, bus.alu_run, bus.wb_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.alu_run !== 1'b0 || bus.wb_valid !== 1'b0 || bus.wb_err !== 1'b0)
      $display("FAIL reset_ctrl: ready/run/valid/err=%b%b%b%b required 1000",
               bus.cmd_ready, bus.alu_run, bus.wb_valid, bus.wb_err);
    else n_pass++;
    n_checks++;
    if (bus.wb_data !== '0 || bus.wb_be !== '0)
      $display("FAIL reset_buffer: be=%h data=%h required 0 0", bus.wb_be, bus.wb_data);
    else n_pass++;
    n_checks++;
    if (dut_ops() !== '0 || dbg_state !== 2'd0)
      $display("FAIL reset_ops: ops=%h state=%0d required 0 0", dut_ops(), dbg_state);
    else n_pass++;
  endtask

  task automatic test_e8_full();
    issue(3'd0, 11'd16);
    check_run_started("e8");
    for (int p = 0; p < 8; p++) beat(2*p, 2*p + 1, p == 7);
    check_done_timing("e8");
    exp_q.push_back({1'b0, m_be, m_data});
    n_checks++;
    if (m_be !== 16'hFFFF) $display("FAIL e8_model_be: be=%h required ffff", m_be);
    else n_pass++;
    collect(0, "e8");
  endtask

  task automatic test_vl_clamp();
    issue(3'd2, 11'd5);
    check_run_started("clamp");
    beat(0, 1, 1'b0);
    beat(2, 3, 1'b0);
    beat(4, -1, 1'b1);
    exp_q.push_back({1'b0, 16'hFFFF, m_data});
    collect(0, "clamp");
  endtask

  task automatic test_degenerate();
    issue(3'd0, 11'd0);
    check_done_timing("vl0");
    exp_q.push_back({1'b0, {NBYTES{1'b0}}, {VLEN{1'b0}}});
    collect(0, "vl0");
    issue(3'd4, 11'd8);
    check_done_timing("vsew4");
    exp_q.push_back({1'b1, {NBYTES{1'b0}}, {VLEN{1'b0}}});
    collect(0, "vsew4");
  endtask

  task automatic test_short();
    issue(3'd0, 11'd16);
    beat(0, 1, 0); beat(2, 3, 0); beat(4, 5, 0); beat(6, -1, 0);
    beat(8, 9, 0); beat(10, 11, 0); beat(12, 13, 0); beat(14, 15, 1);
    check_done_timing("short");
    n_checks++;
    if (bus.wb_be[7] !== 1'b0 || bus.wb_err !== 1'b1)
      $display("FAIL short_be7: be[7]=%b err=%b required 0 1", bus.wb_be[7], bus.wb_err);
    else n_pass++;
    exp_q.push_back({1'b1, m_be, m_data});
    collect(0, "short");
  endtask

  task automatic test_timeout();
    int run_cycles, t;
    issue(3'd0, 11'd16);
    run_cycles = 0;
    t = 0;
    while (bus.wb_valid !== 1'b1 && t < 400) begin
      if (bus.alu_run === 1'b1) run_cycles++;
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (run_cycles != 255) $display("FAIL timeout_cycles: run cycles=%0d required 255", run_cycles);
    else n_pass++;
    exp_q.push_back({1'b1, {NBYTES{1'b0}}, {VLEN{1'b0}}});
    collect(0, "timeout");
  endtask

  task automatic test_duplicates();
    issue(3'd0, 11'd4);
    beat(0, 1, 0);
    beat(1, 2, 0);
    beat(3, 3, 1);
    exp_q.push_back({1'b0, m_be, m_data});
    collect(0, "dup");
  endtask

  task automatic test_back_to_back();
    issue(3'd1, 11'd8);
    beat(0, 1, 0); beat(2, 3, 0); beat(4, 5, 0); beat(6, 7, 1);
    exp_q.push_back({1'b0, m_be, m_data});
    collect(10, "bp_first");
    issue(3'd3, 11'd2);
    check_run_started("bp_second");
    beat(1, 0, 1);
    exp_q.push_back({1'b0, m_be, m_data});
    collect(0, "bp_second");
  endtask

  task automatic test_reset_mid_run();
    bit quiet;
    issue(3'd0, 11'd16);
    beat(0, 1, 0);
    beat(2, 3, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.alu_run !== 1'b0 || bus.wb_valid !== 1'b0 ||
        bus.wb_err !== 1'b0 || bus.wb_data !== '0 || bus.wb_be !== '0 || dut_ops() !== '0)
      $display("FAIL rst_mid_outputs: ready=%b run=%b valid=%b err=%b be=%h required reset values",
               bus.cmd_ready, bus.alu_run, bus.wb_valid, bus.wb_err, bus.wb_be);
    else n_pass++;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.wb_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL rst_mid_no_wb: wb_valid rose after reset");
    else n_pass++;
    issue(3'd2, 11'd4);
    beat(0, 1, 0); beat(2, 3, 1);
    exp_q.push_back({1'b0, m_be, m_data});
    collect(0, "rst_after");
  endtask

  task automatic test_random();
    int order[$];
    int n, sw, vl, j, tmp;
    for (int it = 0; it < 4; it++) begin
      sw = $urandom_range(0, 3);
      vl = $urandom_range(0, 20);
      issue(3'(sw), 11'(vl));
      n = cur_vl_eff;
      order.delete();
      for (int i = 0; i < n; i++) order.push_back(i);
      for (int i = n - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int p = 0; p < n; p += 2) beat(order[p], (p + 1 < n) ? order[p+1] : -1, p + 2 >= n);
      exp_q.push_back({1'b0, m_be, m_data});
      collect($urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_e8_full();
    test_vl_clamp();
    test_degenerate();
    test_short();
    test_timeout();
    test_duplicates();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d entries required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
